sprite_obj_writer: RTL and testbench

SPRITE_OBJ_WRITER -- requirements
Module: sprite_obj_writer

---
 rtl/sprite_obj_writer_pkg.sv | 43 ++++
 rtl/sprite_obj_writer_sync_fifo.sv | 61 ++++++
 rtl/sprite_obj_writer.sv | 175 +++++++++++++++++
 tb/tb_sprite_obj_writer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_obj_writer_pkg.sv
// Shared constants, object-word layout and FSM state type for the sprite object writer.
// The object word packs x, y, sprite and active from the MSB downwards, with bit 0 reserved.
package sprite_obj_writer_pkg;

    localparam int MAX_OBJECTS = 20;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [ADDR_W-1:0] BG_ADDR       = 5'd0;
    localparam logic [ADDR_W-1:0] OBJ_BASE_ADDR = 5'd1;

    localparam int X_LSB      = 20;
    localparam int X_W        = 12;
    localparam int Y_LSB      = 8;
    localparam int Y_W        = 12;
    localparam int SPRITE_LSB = 2;
    localparam int SPRITE_W   = 6;
    localparam int ACTIVE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] pack_obj(
        input logic [X_W-1:0]      x,
        input logic [Y_W-1:0]      y,
        input logic [SPRITE_W-1:0] sprite,
        input logic                active
    );
        logic [DATA_W-1:0] w_word;
        w_word                           = '0;
        w_word[X_LSB +: X_W]             = x;
        w_word[Y_LSB +: Y_W]             = y;
        w_word[SPRITE_LSB +: SPRITE_W]   = sprite;
        w_word[ACTIVE_BIT]               = active;
        return w_word;
    endfunction

endpackage

// File: rtl/sprite_obj_writer_sync_fifo.sv
// Single-clock FIFO with full/empty flags; exposes the head and the entry behind it
// so the writer can preload its registered bus outputs for back-to-back transfers.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [WIDTH-1:0]           o_head_next,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [CW-1:0]    w_count;
    logic [AW-1:0]    w_rd_next_idx;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign o_count       = w_count;
    assign o_full        = (w_count == CW'(DEPTH));
    assign o_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_do_push     = i_push && !o_full;
    assign w_do_pop      = i_pop && !o_empty;
    assign w_rd_next_idx = r_rd_ptr[AW-1:0] + AW'(1);
    assign o_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign o_head_next   = r_mem[w_rd_next_idx];

    // NOTE: storage is not reset; the pointers alone define validity, so clearing
    // them empties the queue and lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // NOTE: state updates use <= so every register samples pre-edge values,
    // independent of the order in which the processes are evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

endmodule

// File: rtl/sprite_obj_writer.sv
// Queues background/object update requests and writes them to the sprite engine
// over Avalon-MM, optionally holding writes back until vertical blank.
module sprite_obj_writer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_OBJECTS = sprite_obj_writer_pkg::MAX_OBJECTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_bg,
    input  logic [4:0]  req_idx,
    input  logic [11:0] req_x,
    input  logic [11:0] req_y,
    input  logic [5:0]  req_sprite,
    input  logic        req_active,
    input  logic [23:0] req_rgb,
    input  logic        gate_en,
    input  logic        vblank,
    output logic [4:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_chipselect,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic [7:0]  drop_count
);

    import sprite_obj_writer_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_illegal;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_hold;
    logic               w_load;
    logic               w_load_next;
    logic [CW-1:0]      w_count;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_head_next;
    logic [ENTRY_W-1:0] w_load_entry;
    logic [ADDR_W-1:0]  r_avm_address;
    logic [DATA_W-1:0]  r_avm_writedata;
    logic               r_avm_write;
    logic               r_avm_chipselect;
    logic [7:0]         r_drop_count;

    assign req_ready = !w_full;
    assign w_accept  = req_valid && req_ready;
    assign w_illegal = !req_is_bg && (32'(req_idx) >= 32'(MAX_OBJECTS));
    assign w_push    = w_accept && !w_illegal;
    assign w_hold    = gate_en && !vblank;

    // Requests are packed into their final bus word at accept time.
    always_comb begin
        w_push_entry = '0;
        if (req_is_bg) begin
            w_push_entry = {BG_ADDR, 8'h00, req_rgb};
        end else begin
            w_push_entry = {req_idx + OBJ_BASE_ADDR,
                            pack_obj(req_x, req_y, req_sprite, req_active)};
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_din       (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_head_next (w_head_next),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_load_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (w_hold) begin
                        w_state_next = ST_GATE;
                    end else begin
                        w_state_next = ST_WRITE;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_GATE: begin
                if (!w_hold) begin
                    w_state_next = ST_WRITE;
                    w_load       = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    w_pop = 1'b1;
                    // Gating is re-evaluated only here, so a stalled transfer is never aborted.
                    if (w_count > CW'(1)) begin
                        if (w_hold) begin
                            w_state_next = ST_GATE;
                        end else begin
                            w_state_next = ST_WRITE;
                            w_load       = 1'b1;
                            w_load_next  = 1'b1;
                        end
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The entry behind the head becomes the head once this cycle's pop lands.
    assign w_load_entry = w_load_next ? w_head_next : w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_avm_write      <= 1'b0;
            r_avm_chipselect <= 1'b0;
            r_avm_address    <= '0;
            r_avm_writedata  <= '0;
        end else begin
            r_avm_write      <= (w_state_next == ST_WRITE);
            r_avm_chipselect <= (w_state_next == ST_WRITE);
            if (w_load) begin
                r_avm_address   <= w_load_entry[ENTRY_W-1 -: ADDR_W];
                r_avm_writedata <= w_load_entry[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_accept && w_illegal && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign avm_address    = r_avm_address;
    assign avm_writedata  = r_avm_writedata;
    assign avm_write      = r_avm_write;
    assign avm_chipselect = r_avm_chipselect;
    assign drop_count     = r_drop_count;
    assign busy           = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_sprite_obj_writer.sv
// Directed self-checking bench for sprite_obj_writer: packing, latency, backpressure,
// vblank gating, illegal-slot drops and asynchronous reset during a stalled write.
module tb_sprite_obj_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_bg;
    logic [4:0]  req_idx;
    logic [11:0] req_x;
    logic [11:0] req_y;
    logic [5:0]  req_sprite;
    logic        req_active;
    logic [23:0] req_rgb;
    logic        gate_en;
    logic        vblank;
    logic [4:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write;
    logic        avm_chipselect;
    logic        avm_waitrequest;
    logic        busy;
    logic [7:0]  drop_count;

    sprite_obj_writer #(
        .FIFO_DEPTH  (8),
        .MAX_OBJECTS (20)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_bg       (req_is_bg),
        .req_idx         (req_idx),
        .req_x           (req_x),
        .req_y           (req_y),
        .req_sprite      (req_sprite),
        .req_active      (req_active),
        .req_rgb         (req_rgb),
        .gate_en         (gate_en),
        .vblank          (vblank),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_chipselect  (avm_chipselect),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .drop_count      (drop_count)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Completed transfers as seen on the bus, with the cycle in which each completed.
    logic [4:0]  cap_addr [$];
    logic [31:0] cap_data [$];
    int          cap_cyc  [$];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && avm_write && avm_chipselect && !avm_waitrequest) begin
            cap_addr.push_back(avm_address);
            cap_data.push_back(avm_writedata);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    // Presents one request and returns in the cycle after it is accepted.
    task automatic push_req(input logic bg, input logic [4:0] idx, input logic [11:0] x,
                            input logic [11:0] y, input logic [5:0] spr, input logic act,
                            input logic [23:0] rgb);
        bit done;
        done       = 1'b0;
        req_is_bg  = bg;
        req_idx    = idx;
        req_x      = x;
        req_y      = y;
        req_sprite = spr;
        req_active = act;
        req_rgb    = rgb;
        req_valid  = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (req_ready) done = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            if (!busy && !avm_write) idle = 1'b1;
            else tick();
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_is_bg       = 1'b0;
        req_idx         = '0;
        req_x           = '0;
        req_y           = '0;
        req_sprite      = '0;
        req_active      = 1'b0;
        req_rgb         = '0;
        gate_en         = 1'b0;
        vblank          = 1'b0;
        avm_waitrequest = 1'b0;
        #25;
        check("rst_ready",  32'(req_ready),      32'd1);
        check("rst_write",  32'(avm_write),      32'd0);
        check("rst_cs",     32'(avm_chipselect), 32'd0);
        check("rst_addr",   32'(avm_address),    32'd0);
        check("rst_data",   avm_writedata,       32'd0);
        check("rst_busy",   32'(busy),           32'd0);
        check("rst_drop",   32'(drop_count),     32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Background write, ungated: avm_write appears two cycles after accept.
        clear_cap();
        push_req(1'b1, 5'd0, 12'd0, 12'd0, 6'd0, 1'b0, 24'h102030);
        check("bg_lat_n1", 32'(avm_write), 32'd0);
        tick();
        check("bg_write", 32'(avm_write),      32'd1);
        check("bg_cs",    32'(avm_chipselect), 32'd1);
        check("bg_addr",  32'(avm_address),    32'd0);
        check("bg_data",  avm_writedata,       32'h00102030);
        tick();
        check("bg_single", 32'(avm_write), 32'd0);
        wait_idle("bg_idle");
        check("bg_count", 32'(cap_addr.size()), 32'd1);

        // Object packing, including the highest legal slot and saturated fields.
        push_req(1'b0, 5'd0, 12'd200, 12'd240, 6'd0, 1'b1, 24'd0);
        tick();
        check("obj0_addr", 32'(avm_address), 32'd1);
        check("obj0_data", avm_writedata,    32'h0C80F002);
        wait_idle("obj0_idle");
        push_req(1'b0, 5'd19, 12'hFFF, 12'd0, 6'h3F, 1'b0, 24'd0);
        tick();
        check("obj19_addr", 32'(avm_address), 32'd20);
        check("obj19_data", avm_writedata,    32'hFFF000FC);
        wait_idle("obj19_idle");

        // Backpressure: eight fill the queue while the first write is stalled.
        clear_cap();
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_req(1'b0, 5'(k), 12'(k), 12'd0, 6'd0, 1'b1, 24'd0);
        end
        check("bp_full_ready", 32'(req_ready), 32'd0);
        req_is_bg  = 1'b0;
        req_idx    = 5'd8;
        req_x      = 12'd8;
        req_y      = 12'd0;
        req_sprite = 6'd0;
        req_active = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_write", 32'(avm_write),   32'd1);
            check("bp_hold_addr",  32'(avm_address), 32'd1);
            check("bp_hold_data",  avm_writedata,    32'h00000002);
            check("bp_hold_ready", 32'(req_ready),   32'd0);
            tick();
        end
        avm_waitrequest = 1'b0;
        begin
            bit acc;
            acc = 1'b0;
            for (int i = 0; i < 20 && !acc; i++) begin
                if (req_ready) acc = 1'b1;
                tick();
            end
            req_valid = 1'b0;
            check("bp_ninth_accept", 32'(acc), 32'd1);
        end
        wait_idle("bp_idle");
        check("bp_count", 32'(cap_addr.size()), 32'd9);
        for (int k = 0; k < 9; k++) begin
            check("bp_order_addr", (k < cap_addr.size()) ? 32'(cap_addr[k]) : 32'hFFFF_FFFF,
                  32'(k + 1));
            check("bp_order_data", (k < cap_data.size()) ? cap_data[k] : 32'hFFFF_FFFF,
                  32'h0010_0000 * 32'(k) + 32'd2);
        end
        check("bp_sustain_span",
              (cap_cyc.size() >= 9) ? 32'(cap_cyc[8] - cap_cyc[0]) : 32'hFFFF_FFFF, 32'd8);

        // Gated: held in GATE until vblank, then writes on the following cycle.
        gate_en = 1'b1;
        vblank  = 1'b0;
        clear_cap();
        push_req(1'b0, 5'd3, 12'd100, 12'd50, 6'd7, 1'b1, 24'd0);
        for (int i = 0; i < 3; i++) begin
            check("gate_no_write", 32'(avm_write), 32'd0);
            check("gate_busy",     32'(busy),      32'd1);
            tick();
        end
        vblank = 1'b1;
        check("gate_vb_same", 32'(avm_write), 32'd0);
        tick();
        check("gate_vb_write", 32'(avm_write),   32'd1);
        check("gate_vb_addr",  32'(avm_address), 32'd4);
        check("gate_vb_data",  avm_writedata,    32'h0640321E);
        wait_idle("gate_idle");

        // vblank falls during a stalled transfer: it completes, the next entry waits.
        avm_waitrequest = 1'b1;
        push_req(1'b1, 5'd0, 12'd0, 12'd0, 6'd0, 1'b0, 24'hAABBCC);
        push_req(1'b1, 5'd0, 12'd0, 12'd0, 6'd0, 1'b0, 24'h112233);
        vblank = 1'b0;
        tick();
        tick();
        check("vbfall_hold_write", 32'(avm_write), 32'd1);
        check("vbfall_hold_data",  avm_writedata,  32'h00AABBCC);
        avm_waitrequest = 1'b0;
        tick();
        check("vbfall_next_gated", 32'(avm_write), 32'd0);
        tick();
        check("vbfall_still_gated", 32'(avm_write), 32'd0);
        check("vbfall_busy",        32'(busy),      32'd1);
        vblank = 1'b1;
        tick();
        check("vbfall_resume_write", 32'(avm_write), 32'd1);
        check("vbfall_resume_data",  avm_writedata,  32'h00112233);
        wait_idle("vbfall_idle");
        vblank  = 1'b0;
        gate_en = 1'b0;

        // Illegal slots are dropped; background ignores the slot index.
        clear_cap();
        push_req(1'b0, 5'd20, 12'd1, 12'd1, 6'd1, 1'b1, 24'd0);
        push_req(1'b0, 5'd31, 12'd1, 12'd1, 6'd1, 1'b1, 24'd0);
        tick();
        tick();
        check("drop_no_write", 32'(cap_addr.size()), 32'd0);
        check("drop_two",      32'(drop_count),      32'd2);
        check("drop_idle",     32'(busy),            32'd0);
        push_req(1'b1, 5'd31, 12'd0, 12'd0, 6'd0, 1'b0, 24'h0000FF);
        tick();
        check("bg31_addr", 32'(avm_address), 32'd0);
        check("bg31_data", avm_writedata,    32'h000000FF);
        check("bg31_drop", 32'(drop_count),  32'd2);
        wait_idle("bg31_idle");
        req_is_bg = 1'b0;
        req_idx   = 5'd25;
        req_valid = 1'b1;
        repeat (300) tick();
        req_valid = 1'b0;
        tick();
        check("drop_saturate", 32'(drop_count),      32'd255);
        check("drop_sat_none", 32'(cap_addr.size()), 32'd1);

        // Reset mid-transfer with three entries queued.
        clear_cap();
        avm_waitrequest = 1'b1;
        push_req(1'b0, 5'd1, 12'd1, 12'd0, 6'd0, 1'b1, 24'd0);
        push_req(1'b0, 5'd2, 12'd2, 12'd0, 6'd0, 1'b1, 24'd0);
        push_req(1'b0, 5'd3, 12'd3, 12'd0, 6'd0, 1'b1, 24'd0);
        check("rstmid_pre_write", 32'(avm_write), 32'd1);
        #5;
        reset = 1'b1;
        #1;
        check("rstmid_write", 32'(avm_write),      32'd0);
        check("rstmid_cs",    32'(avm_chipselect), 32'd0);
        check("rstmid_busy",  32'(busy),           32'd0);
        check("rstmid_ready", 32'(req_ready),      32'd1);
        tick();
        reset           = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (5) tick();
        check("rstmid_after_busy",  32'(busy),            32'd0);
        check("rstmid_after_write", 32'(avm_write),       32'd0);
        check("rstmid_after_none",  32'(cap_addr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
